// File: rtl/edge_tx_pkg.sv
// Shared types and helpers for the two-phase event transmitter.
package edge_tx_pkg;

  typedef enum logic {
    StIdle,
    StHold
  } state_e;

  // Hold timer width: $clog2(hold), never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/edge_event_tx_hold_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module hold_timer #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/edge_event_tx.sv
// Two-phase event transmitter: each queued event becomes one transition on tx_line,
// with transitions spaced at least HOLD_CYCLES clocks apart.
module edge_event_tx
  import edge_tx_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ev_valid,
  output logic             ev_ready,
  input  logic             clr_ovf,
  output logic             tx_line,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
  localparam int unsigned      TimerW   = timer_width(HOLD_CYCLES);
  localparam logic [TimerW-1:0] HoldLoad = TimerW'(HOLD_CYCLES - 1);

  state_e           state_d, state_q;
  logic             tx_line_d, tx_line_q;
  logic [CNT_W-1:0] pending_d, pending_q;
  logic             overflow_d, overflow_q;

  logic hold_zero;
  logic send_ok;
  logic toggle;
  logic accept;

  hold_timer #(
    .Width (TimerW)
  ) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (toggle),
    .load_val (HoldLoad),
    .zero     (hold_zero)
  );

  assign ev_ready = (pending_q != PEND_MAX);
  assign accept   = ev_valid && ev_ready;
  assign send_ok  = (state_q == StIdle) || ((state_q == StHold) && hold_zero);
  // Only registered pending feeds the send decision, so an event never bypasses the queue.
  assign toggle   = send_ok && (pending_q != '0);

  always_comb begin
    state_d    = state_q;
    tx_line_d  = tx_line_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    if (toggle) begin
      state_d   = StHold;
      tx_line_d = ~tx_line_q;
    end else if ((state_q == StHold) && hold_zero && (pending_q == '0)) begin
      state_d = StIdle;
    end

    unique case ({accept, toggle})
      2'b10:   pending_d = pending_q + CNT_W'(1);
      2'b01:   pending_d = pending_q - CNT_W'(1);
      default: pending_d = pending_q;
    endcase

    // A dropped request wins over a simultaneous clear.
    if (ev_valid && !ev_ready) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      tx_line_q  <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_line_q  <= tx_line_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_line  = tx_line_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign busy     = (state_q == StHold) || (pending_q != '0);

endmodule

// File: tb/tb_edge_event_tx.sv
// Scoreboard bench for edge_event_tx against an event-level reference model.
module tb_edge_event_tx;

  localparam int unsigned HOLD = 3;
  localparam int unsigned CW   = 3;
  localparam int          PMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ev_valid = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          ev_ready;
  logic          tx_line;
  logic [CW-1:0] pending;
  logic          busy;
  logic          overflow;

  edge_event_tx #(
    .HOLD_CYCLES (HOLD),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .clr_ovf  (clr_ovf),
    .tx_line  (tx_line),
    .pending  (pending),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   edge_n;
    logic level;
  } tog_t;

  tog_t exp_q[$];
  tog_t mon_e;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   m_pend   = 0;
  int   m_last   = -1000;
  logic m_tx     = 1'b0;
  logic m_ovf    = 1'b0;
  bit   mon_en   = 1'b0;
  logic prev_tx  = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Apply one cycle of inputs, then advance the reference model by that edge.
  task automatic drive(input logic ev, input logic clr, input logic rst);
    bit tog;
    bit acc;
    ev_valid = ev;
    clr_ovf  = clr;
    reset    = rst;
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      if (m_tx) exp_q.push_back('{cyc, 1'b0});
      m_tx   = 1'b0;
      m_pend = 0;
      m_ovf  = 1'b0;
      m_last = -1000;
    end else begin
      tog = (m_pend > 0) && (cyc - m_last >= int'(HOLD));
      acc = ev && (m_pend < PMAX);
      if (ev && (m_pend == PMAX)) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_pend = m_pend + int'(acc) - int'(tog);
      if (tog) begin
        m_tx   = ~m_tx;
        m_last = cyc;
        exp_q.push_back('{cyc, m_tx});
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("pending", int'(pending), m_pend);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("ev_ready", int'(ev_ready), int'(m_pend != PMAX));
      chk("busy", int'(busy), int'((m_pend != 0) || (cyc - m_last < int'(HOLD))));
      if (tx_line !== prev_tx) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_toggle", int'(tx_line), int'(prev_tx));
        end else begin
          mon_e = exp_q.pop_front();
          chk("toggle_edge", cyc, mon_e.edge_n);
          chk("toggle_level", int'(tx_line), int'(mon_e.level));
        end
        prev_tx = tx_line;
      end else if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("missed_toggle", int'(tx_line), int'(mon_e.level));
      end
    end
  end

  initial begin
    int pct;
    drive(1'b0, 1'b0, 1'b1);
    prev_tx = 1'b0;
    mon_en  = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    repeat (6) drive(1'b0, 1'b0, 1'b0);

    // Single event, then a short burst.
    drive(1'b1, 1'b0, 1'b0);
    repeat (8) drive(1'b0, 1'b0, 1'b0);
    repeat (5) drive(1'b1, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 1'b0, 1'b0);

    // Saturate, clear, then refill and collide clear with a drop.
    repeat (14) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (6) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Reset with work queued; line must stay quiet afterwards.
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    repeat (10) drive(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      unique case ((i / 100) % 3)
        0:       pct = 90;
        1:       pct = 30;
        default: pct = 60;
      endcase
      drive($urandom_range(0, 99) < pct, $urandom_range(0, 19) == 0,
            $urandom_range(0, 149) == 0);
    end

    repeat (40) drive(1'b0, 1'b0, 1'b0);
    chk("queue_empty", exp_q.size(), 0);
    chk("final_pending", int'(pending), 0);
    chk("final_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_event_tx.md
Name: edge_event_tx

Overview:
- Transition-signalling (two-phase) transmitter.
- Converts single-cycle event requests into level toggles on one wire, `tx_line`. Each toggle carries exactly one event.
- Queues events in a saturating pending counter. Spaces toggles at least HOLD_CYCLES clocks apart so a downstream dual-edge detector recovers exactly one pulse per event.
- Sits on the sending side of the event wire, opposite the team's both-edge detector.

Parameters:
- HOLD_CYCLES, default 2: minimum clock cycles between consecutive toggles of `tx_line`. Legal range is 1 or more; 1 allows a toggle every cycle.
- CNT_W, default 4: width of the pending-event counter. Capacity is 2^CNT_W-1 events.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- ev_valid, input, 1: event request; one event per cycle in which ev_valid && ev_ready.
- ev_ready, output, 1: combinational; high when pending != 2^CNT_W-1.
- clr_ovf, input, 1: clears the sticky overflow flag.
- tx_line, output, 1: registered transition-signalled event line.
- pending, output, CNT_W: registered count of accepted, not-yet-sent events.
- busy, output, 1: combinational; (state==HOLD) || (pending != 0).
- overflow, output, 1: registered sticky flag; set when ev_valid && !ev_ready.

Behaviour:
- Reset (synchronous, active-high; clock clk), on the next edge:
  - tx_line=0, pending=0, state=IDLE, hold_cnt=0, overflow=0.
  - ev_ready=1 and busy=0 follow combinationally.
  - Reset mid-operation discards queued events and forces tx_line to 0. The receiver is reset by the same reset, so no spurious event is counted.
- States are IDLE and HOLD.
- send_ok = (state==IDLE) || (state==HOLD && hold_cnt==0).
- Toggle edge: send_ok && pending!=0. On that edge:
  - tx_line <= ~tx_line.
  - state <= HOLD.
  - hold_cnt <= HOLD_CYCLES-1.
- HOLD with hold_cnt!=0: hold_cnt decrements.
- HOLD with hold_cnt==0 and pending==0: state <= IDLE.
- Spacing: consecutive toggles are exactly HOLD_CYCLES edges apart while pending stays nonzero, and never closer.
- Latency:
  - ev_valid sampled at edge N with the block idle and pending 0: pending=1 after N, tx_line toggles at N+1, pending=0 after N+1.
  - Pending events are never sent in the same cycle they are accepted (no bypass).
- Pending counter update per edge:
  - +1 if accept.
  - -1 if toggle.
  - Net 0 if both occur.
- Saturation:
  - At pending = 2^CNT_W-1, ev_ready=0 and the request is dropped.
  - overflow <= 1 on that edge.
  - An accept and a toggle on the same cycle at full cannot occur, because ev_ready is low; the send still decrements the counter.
- Overflow flag:
  - overflow stays set until a clr_ovf edge.
  - If set and clear conditions coincide, set wins.
- Event ordering is irrelevant: all events are identical. Polarity of tx_line carries no meaning; only transitions do.
- No combinational path from ev_valid to tx_line.

Decomposition:
- Package edge_tx_pkg holds:
  - State enum {IDLE, HOLD}.
  - Localparam PEND_MAX = 2^CNT_W-1, computed in the module from CNT_W.
- One natural sub-module, hold_timer:
  - Loadable down-counter with a zero flag.
  - Width $clog2(HOLD_CYCLES) (minimum 1).
  - Ports: clk, reset, load, load_val, zero.
- The counter, FSM and flag logic stay in edge_event_tx.

Test Plan:
1. Reset, then a single ev_valid pulse at edge 10 (HOLD_CYCLES=2) -> pending=1 after edge 10; tx_line 0→1 at edge 11; pending=0, busy=0 from edge 13.
2. ev_valid held high for 5 cycles, edges 10–14 (HOLD_CYCLES=3) -> tx_line toggles at edges 11, 14, 17, 20, 23; final tx_line=1; no toggle spacing below 3.
3. HOLD_CYCLES=1, ev_valid high for 4 cycles -> tx_line toggles every edge 11–14; pending stays 1 from edge 10 to 13, 0 after edge 14; a both-edge detector on tx_line produces exactly 4 pulses.
4. CNT_W=2, HOLD_CYCLES=8, ev_valid high for 6 cycles -> pending peaks at 3; ev_ready=0 while pending=3; overflow=1 and stays set; exactly 4 toggles total (1 sent plus 3 queued); pulse clr_ovf -> overflow=0 next edge.
5. clr_ovf and an overflow condition in the same cycle -> overflow remains 1.
6. Reset asserted with pending=5 and tx_line=1 -> next edge: tx_line=0, pending=0, overflow=0, busy=0, ev_ready=1; no further toggles without new events.
